// File: rtl/tft_spi_decoder.sv
// Receive-side TFT SPI decoder: synchronises the 4-wire display bus, deserialises bytes
// and turns CASET/RASET/RAMWR traffic into windowed RGB565 pixel writes.
module tft_spi_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int COORD_W     = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_clk,
  input  logic               spi_mosi,
  input  logic               spi_dc,
  input  logic               spi_cs,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_dc,
  output logic               cmd_valid,
  output logic [7:0]         cmd_code,
  output logic               pixel_valid,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic [15:0]        pixel_color,
  output logic [COORD_W-1:0] win_xs,
  output logic [COORD_W-1:0] win_xe,
  output logic [COORD_W-1:0] win_ys,
  output logic [COORD_W-1:0] win_ye
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] CASET_P0 = 4'd1;
  localparam logic [3:0] CASET_P3 = 4'd4;
  localparam logic [3:0] RASET_P0 = 4'd5;
  localparam logic [3:0] RASET_P3 = 4'd8;
  localparam logic [3:0] RAM_HI   = 4'd9;
  localparam logic [3:0] RAM_LO   = 4'd10;

  // All four pins share one chain so mosi/dc/cs stay aligned with the clock edge.
  logic [SYNC_STAGES-1:0][3:0] sync;
  logic                        s_clk, s_mosi, s_dc, s_cs, clk_prev, rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync[0] <= {spi_cs, spi_dc, spi_mosi, spi_clk};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  assign {s_cs, s_dc, s_mosi, s_clk} = sync[SYNC_STAGES-1];
  assign rise = s_clk & ~clk_prev;

  logic [2:0] bit_cnt;
  logic [6:0] shift;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_prev   <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      clk_prev   <= s_clk;
      byte_valid <= 1'b0;
      if (s_cs) begin
        bit_cnt <= '0;
      end else if (rise) begin
        shift   <= {shift[5:0], s_mosi};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift, s_mosi};
          byte_dc    <= s_dc;
        end
      end
    end
  end

  logic [3:0]         state;
  logic [7:0]         p_sh, p_sl, p_eh, ram_hi;
  logic [COORD_W-1:0] cur_x, cur_y, nxt_x, nxt_y;
  logic [15:0]        start_w, end_w;

  assign start_w = {p_sh, p_sl};
  assign end_w   = {p_eh, byte_data};

  // Raster advance; unsigned compares make an inverted window degenerate to one column/row.
  always_comb begin
    nxt_x = cur_x + 1'b1;
    nxt_y = cur_y;
    if (cur_x >= win_xe) begin
      nxt_x = win_xs;
      nxt_y = (cur_y >= win_ye) ? win_ys : cur_y + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_color <= '0;
      win_xs      <= '0;
      win_xe      <= '1;
      win_ys      <= '0;
      win_ye      <= '1;
      cur_x       <= '0;
      cur_y       <= '0;
      p_sh        <= '0;
      p_sl        <= '0;
      p_eh        <= '0;
      ram_hi      <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      if (byte_valid) begin
        if (!byte_dc) begin
          cmd_valid <= 1'b1;
          cmd_code  <= byte_data;
          case (byte_data)
            8'h2A:   state <= CASET_P0;
            8'h2B:   state <= RASET_P0;
            8'h2C: begin
              state <= RAM_HI;
              cur_x <= win_xs;
              cur_y <= win_ys;
            end
            default: state <= IDLE;
          endcase
        end else begin
          case (state)
            CASET_P0, RASET_P0: begin p_sh <= byte_data; state <= state + 4'd1; end
            4'd2, 4'd6:         begin p_sl <= byte_data; state <= state + 4'd1; end
            4'd3, 4'd7:         begin p_eh <= byte_data; state <= state + 4'd1; end
            CASET_P3: begin
              win_xs <= start_w[COORD_W-1:0];
              win_xe <= end_w[COORD_W-1:0];
              state  <= IDLE;
            end
            RASET_P3: begin
              win_ys <= start_w[COORD_W-1:0];
              win_ye <= end_w[COORD_W-1:0];
              state  <= IDLE;
            end
            RAM_HI: begin
              ram_hi <= byte_data;
              state  <= RAM_LO;
            end
            RAM_LO: begin
              pixel_valid <= 1'b1;
              pixel_x     <= cur_x;
              pixel_y     <= cur_y;
              pixel_color <= {ram_hi, byte_data};
              cur_x       <= nxt_x;
              cur_y       <= nxt_y;
              state       <= RAM_HI;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
